// File: rtl/mem_fwd_history_unit.sv
// MEM-stage store-data forwarding over the live WB write plus a DEPTH-entry retire history.
// Optional build macro MEMFWD_ALU_SRC_EN makes ALU-result writes eligible as forwarding sources.
module mem_fwd_history_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_regwrite,
  input  logic              wb_wbsrc,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rs2,
  input  logic [XLEN-1:0]   mem_rs2_data,
  input  logic              cnt_clr,
  output logic [XLEN-1:0]   mem_store_data,
  output logic              mem_fwd_sig,
  output logic [2:0]        mem_fwd_src,
  output logic [CNT_W-1:0]  fwd_count
);

  logic              hist_vld  [1:DEPTH];
  logic [REG_AW-1:0] hist_rd   [1:DEPTH];
  logic [XLEN-1:0]   hist_data [1:DEPTH];
  logic              hist_src  [1:DEPTH];

  logic              live_vld;
  logic              hit;
  logic              hit_src;
  logic [XLEN-1:0]   hit_data;
  logic [2:0]        hit_idx;
  logic              eligible;
  logic              fwd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign live_vld = wb_regwrite && (wb_rd != '0);

  // Stage p0: youngest-match search, live WB first then history oldest-last
  always_comb begin
    hit      = 1'b0;
    hit_src  = 1'b0;
    hit_data = '0;
    hit_idx  = 3'd0;
    if (live_vld && (wb_rd == mem_rs2)) begin
      hit      = 1'b1;
      hit_src  = wb_wbsrc;
      hit_data = wb_data;
      hit_idx  = 3'd1;
    end
    for (int k = 1; k <= DEPTH; k++) begin
      if (!hit && hist_vld[k] && (hist_rd[k] == mem_rs2)) begin
        hit      = 1'b1;
        hit_src  = hist_src[k];
        hit_data = hist_data[k];
        hit_idx  = 3'(k + 1);
      end
    end
  end

  // Only the youngest match is judged; an ineligible one shadows older ones.
`ifdef MEMFWD_ALU_SRC_EN
  assign eligible = hit;
`else
  assign eligible = hit && hit_src;
`endif

  assign fwd            = eligible && mem_valid;
  assign mem_fwd_sig    = fwd;
  assign mem_store_data = fwd ? hit_data : mem_rs2_data;
  assign mem_fwd_src    = fwd ? hit_idx : 3'd0;

  // Stage p1: history shift, every cycle regardless of mem_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        hist_vld[k]  <= 1'b0;
        hist_rd[k]   <= '0;
        hist_data[k] <= '0;
        hist_src[k]  <= 1'b0;
      end
    end else begin
      hist_vld[1]  <= live_vld;
      hist_rd[1]   <= wb_rd;
      hist_data[1] <= wb_data;
      hist_src[1]  <= wb_wbsrc;
      for (int k = 2; k <= DEPTH; k++) begin
        hist_vld[k]  <= hist_vld[k-1];
        hist_rd[k]   <= hist_rd[k-1];
        hist_data[k] <= hist_data[k-1];
        hist_src[k]  <= hist_src[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count <= '0;
    end else if (cnt_clr) begin
      fwd_count <= '0;
    end else if (fwd) begin
      fwd_count <= sat_inc(fwd_count);
    end
  end

endmodule

// File: tb/tb_mem_fwd_history_unit.sv
// Self-checking bench for mem_fwd_history_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the retire history.
module tb_mem_fwd_history_unit;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;
`ifdef MEMFWD_ALU_SRC_EN
  localparam bit ALU_EN = 1'b1;
`else
  localparam bit ALU_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wb_regwrite;
  logic              wb_wbsrc;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              mem_valid;
  logic [REG_AW-1:0] mem_rs2;
  logic [XLEN-1:0]   mem_rs2_data;
  logic              cnt_clr;
  logic [XLEN-1:0]   mem_store_data;
  logic              mem_fwd_sig;
  logic [2:0]        mem_fwd_src;
  logic [CNT_W-1:0]  fwd_count;

  mem_fwd_history_unit #(.XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_regwrite(wb_regwrite), .wb_wbsrc(wb_wbsrc), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_valid(mem_valid), .mem_rs2(mem_rs2), .mem_rs2_data(mem_rs2_data),
    .cnt_clr(cnt_clr),
    .mem_store_data(mem_store_data), .mem_fwd_sig(mem_fwd_sig),
    .mem_fwd_src(mem_fwd_src), .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic              src;
  } wr_t;

  wr_t hist_q[$];
  int  exp_cnt;
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_eval(output logic f, output logic [XLEN-1:0] d,
                                     output logic [2:0] s);
    logic            found;
    logic            msrc;
    logic [XLEN-1:0] mdata;
    int              idx;
    found = 1'b0; msrc = 1'b0; mdata = '0; idx = 0;
    if (wb_regwrite && wb_rd != 0 && wb_rd == mem_rs2) begin
      found = 1'b1; msrc = wb_wbsrc; mdata = wb_data; idx = 1;
    end
    for (int i = 0; i < hist_q.size(); i++) begin
      if (!found && hist_q[i].v && hist_q[i].rd == mem_rs2) begin
        found = 1'b1; msrc = hist_q[i].src; mdata = hist_q[i].data; idx = i + 2;
      end
    end
    f = found && (ALU_EN || msrc) && mem_valid;
    d = f ? mdata : mem_rs2_data;
    s = f ? 3'(idx) : 3'd0;
  endfunction

  task automatic check_outputs(input string tag);
    logic            ef;
    logic [XLEN-1:0] ed;
    logic [2:0]      es;
    model_eval(ef, ed, es);
    check({tag, ".sig"},  64'(mem_fwd_sig),    64'(ef));
    check({tag, ".data"}, 64'(mem_store_data), 64'(ed));
    check({tag, ".src"},  64'(mem_fwd_src),    64'(es));
    check({tag, ".cnt"},  64'(fwd_count),      64'(exp_cnt));
  endtask

  task automatic drive(input logic rw, input logic src, input logic [REG_AW-1:0] rd,
                       input logic [XLEN-1:0] d, input logic mv,
                       input logic [REG_AW-1:0] rs2, input logic [XLEN-1:0] rsd,
                       input logic clr);
    wb_regwrite = rw; wb_wbsrc = src; wb_rd = rd; wb_data = d;
    mem_valid = mv; mem_rs2 = rs2; mem_rs2_data = rsd; cnt_clr = clr;
  endtask

  // Check this cycle's outputs, then clock and advance the model.
  task automatic tick(input string tag);
    logic            ef;
    logic [XLEN-1:0] ed;
    logic [2:0]      es;
    wr_t             w;
    #1;
    check_outputs(tag);
    model_eval(ef, ed, es);
    @(posedge clk);
    if (cnt_clr) exp_cnt = 0;
    else if (ef && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    w.v = wb_regwrite && (wb_rd != 0); w.rd = wb_rd; w.data = wb_data; w.src = wb_wbsrc;
    hist_q.push_front(w);
    if (hist_q.size() > DEPTH) void'(hist_q.pop_back());
    #1;
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    hist_q.delete();
    exp_cnt = 0;
    wb_regwrite = 1'b0;
    #1;
    check_outputs(tag);
    check({tag, ".pass"}, 64'(mem_store_data), 64'(mem_rs2_data));
    rst_n = 1'b1;
  endtask

  initial begin
    exp_cnt = 0;
    drive(0, 0, 0, 0, 0, 0, 32'h1234, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.cnt", 64'(fwd_count), 64'd0);
    check("reset.sig", 64'(mem_fwd_sig), 64'd0);
    check("reset.data", 64'(mem_store_data), 64'h1234);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Live WB load forward
    drive(1, 1, 5, 32'hDEADBEEF, 1, 5, 32'h0, 0);
    #1;
    check("live.data", 64'(mem_store_data), 64'hDEADBEEF);
    check("live.src", 64'(mem_fwd_src), 64'd1);
    tick("live");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("live.cnt1", 64'(fwd_count), 64'd1);
    tick("idle0");

    // Load reaches hist[2] then ages out
    drive(1, 1, 7, 32'h11, 0, 0, 0, 0);        tick("x7.t");
    drive(0, 0, 0, 0, 0, 0, 0, 0);             tick("x7.t1");
    drive(0, 0, 0, 0, 1, 7, 32'h99, 0);
    #1;
    check("x7.t2.data", 64'(mem_store_data), 64'h11);
    check("x7.t2.src", 64'(mem_fwd_src), 64'd3);
    tick("x7.t2");
    #1;
    check("x7.t3.data", 64'(mem_store_data), 64'h99);
    check("x7.t3.sig", 64'(mem_fwd_sig), 64'd0);
    tick("x7.t3");

    // Shadowing of an older load by a younger ALU write
    drive(1, 1, 3, 32'hAA, 0, 0, 0, 0);        tick("shd.t");
    drive(1, 0, 3, 32'hBB, 0, 0, 0, 0);        tick("shd.t1");
    drive(0, 0, 0, 0, 1, 3, 32'h55, 0);
    #1;
    if (ALU_EN) begin
      check("shd.data", 64'(mem_store_data), 64'hBB);
      check("shd.src", 64'(mem_fwd_src), 64'd2);
    end else begin
      check("shd.data", 64'(mem_store_data), 64'h55);
      check("shd.sig", 64'(mem_fwd_sig), 64'd0);
    end
    tick("shd.t2");

    // x0 never matches
    drive(1, 1, 0, 32'hCAFE, 1, 0, 32'h77, 0); tick("x0.a");
    drive(0, 0, 0, 0, 1, 0, 32'h78, 0);        tick("x0.b");
    check("x0.c.sig", 64'(mem_fwd_sig), 64'd0);
    tick("x0.c");

    // Counter saturation, then clear beating a simultaneous event
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 6, 32'(i), 1, 6, 32'hF0, 0);
      tick("sat");
    end
    check("sat.cnt", 64'(fwd_count), 64'd15);
    drive(1, 1, 6, 32'h1, 1, 6, 32'hF0, 1);    tick("clr");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("clr.cnt", 64'(fwd_count), 64'd0);
    tick("clr.after");

    // Async reset discards history holding x9
    drive(1, 1, 9, 32'h999, 0, 0, 0, 0);       tick("x9.w");
    async_reset("x9.rst");
    drive(0, 0, 0, 0, 1, 9, 32'h42, 0);
    #1;
    check("x9.sig", 64'(mem_fwd_sig), 64'd0);
    check("x9.data", 64'(mem_store_data), 64'h42);
    tick("x9.store");

    // Randomized traffic on a small register set
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            $urandom, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 15) == 0));
      tick("rnd");
      if (i % 97 == 96) async_reset("rnd.rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
